pixel_window_sequencer: RTL
===========================

// Module: pixel_window_sequencer
// PURPOSE
// - Upstream master of Read_Write: walks interior pixels of an image in memory, reads each 3x3
//   neighbourhood via start_read/addr_r_mc, presents the window to the Sobel core, then writes the
//   core result back via start_write/addr_w_mc/data_w. Border pixels are never written.
// PARAMETERS
// - IMG_W    8    image width in pixels (>=3)
// - IMG_H    8    image height in pixels (>=3)
// - ADDR_W   8    memory address width
// - DATA_W   8    pixel width
// - RD_BASE  0    base address of input image (row-major)
// - WR_BASE  128  base address of output image (same geometry); both regions must fit in 2**ADDR_W
//   (elaboration $error otherwise)
// PORTS
// - clk          in   1          clock, rising edge
// - rst          in   1          asynchronous, active-high reset
// - start        in   1          1-cycle go pulse; ignored unless IDLE
// - busy         in   1          memory busy (from Read_Write side)
// - rd_data      in   DATA_W     read data (Read_Write data_r_o)
// - write_done   in   1          write acknowledge
// - start_read   out  1          read request
// - addr_r_mc    out  ADDR_W     read address
// - start_write  out  1          write request
// - addr_w_mc    out  ADDR_W     write address
// - data_w       out  DATA_W     write data
// - win_valid    out  1          1-cycle pulse: win_data holds complete window
// - win_data     out  9*DATA_W   tap k=(dr+1)*3+(dc+1) at [k*DATA_W +: DATA_W]; tap 0 = top-left
// - result_valid in   1          core result strobe
// - result_data  in   DATA_W     core result
// - done         out  1          1-cycle pulse after final write
// BEHAVIOUR
// - Reset: all outputs 0, row=col=1, tap=0, state IDLE; async assert aborts any transaction at once.
// - FSM: IDLE -start-> RD_REQ -(9 taps captured)-> WIN_OUT(1 cycle, win_valid=1) -> RES_WAIT
//   -result_valid-> WR_REQ -write_done-> NEXT -> RD_REQ | DONE(done=1) -> IDLE.
// - Read: RD_REQ drives start_read=1, addr_r_mc = RD_BASE+(row+dr)*IMG_W+(col+dc), held stable
//   until an edge with busy=0; that edge captures rd_data into tap and advances tap (row-major).
//   busy=1 -> request and address held, nothing captured. 1 cycle/tap when busy=0.
// - Write: WR_REQ drives start_write=1, addr_w_mc = WR_BASE+row*IMG_W+col, data_w=latched result,
//   held until write_done=1 sampled; deasserted next cycle. Never start_read & start_write together.
// - result_valid outside RES_WAIT ignored. start outside IDLE ignored.
// - Scan: col 1..IMG_W-2 inner, row 1..IMG_H-2 outer; DONE after (IMG_W-2)*(IMG_H-2) writes.
// - Address arithmetic in ADDR_W bits, unsigned; parameter check guarantees no wrap.
// - Latency per pixel, busy=0, immediate result/ack: 9 reads+1 WIN_OUT+1 RES_WAIT+1 WR_REQ+1 NEXT.
// CONFIGURATION
// - WINDOW_REUSE_EN defined: on col advance within a row, taps shift left one column (taps 1,2->0,1;
//   4,5->3,4; 7,8->6,7) and only column dc=+1 is read (3 reads, taps 2,5,8). First pixel of each
//   row reads all 9. Undefined: every pixel reads all 9 taps.
// STRUCTURE
// - sobel_pkg: state enum, TAP_* constants, window_t (9 x DATA_W packed).
// - Sub-module window_addr_gen: (row,col,tap) -> read/write address, combinational.
// TESTING (IMG_W=IMG_H=4, RD_BASE=0, WR_BASE=128, memory model mem[a]=a)
// - Reset mid-RD_REQ -> start_read=0 same cycle; after start, reads restart at tap 0, addr 0.
// - start, busy=0 -> addr_r_mc sequence 0,1,2,4,5,6,8,9,10; win_data taps = same values; win_valid 1 cycle.
// - busy high 5 cycles during tap 3 -> start_read held, addr_r_mc=4 stable, tap 3 captured once.
// - result_valid with 0xAB -> start_write=1, addr_w_mc=133, data_w=0xAB held until write_done.
// - Full run -> writes to 133,134,137,138 in order; done pulses once; 36 reads (24 with WINDOW_REUSE_EN).
// - result_valid pulsed during RD_REQ and start pulsed mid-run -> no effect on sequence.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the pixel window sequencer: FSM states, tap
// indices and tap-to-offset helpers.
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_WIN_OUT,
    ST_RES_WAIT,
    ST_WR_REQ,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int NUM_TAPS = 9;
  localparam int PIX_W    = 8;

  localparam logic [3:0] TAP_FIRST       = 4'd0;
  localparam logic [3:0] TAP_REUSE_FIRST = 4'd2;
  localparam logic [3:0] TAP_LAST        = 4'd8;
  localparam logic [3:0] TAP_STEP        = 4'd1;
  localparam logic [3:0] TAP_COL_STEP    = 4'd3;

  typedef logic [NUM_TAPS-1:0][PIX_W-1:0] window_t;

  // Row index 0..2 of a tap (tap = dr*3 + dc, row-major).
  function automatic logic [1:0] tap_dr(input logic [3:0] tap);
    if (tap < 4'd3)      return 2'd0;
    else if (tap < 4'd6) return 2'd1;
    else                 return 2'd2;
  endfunction

  function automatic logic [1:0] tap_dc(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Combinational address generator: maps (row, col, tap) to the neighbourhood
// read address and the centre-pixel write address.
module window_addr_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int RD_BASE = 0,
  parameter int WR_BASE = 128,
  parameter int ROW_W   = 3,
  parameter int COL_W   = 3
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [3:0]        tap,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr
);

  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_col;

  always_comb begin
    // Tap row/col 0..2 are offsets -1..+1 around the centre pixel.
    rd_row  = ADDR_W'(row) + ADDR_W'(tap_dr(tap)) - ADDR_W'(1);
    rd_col  = ADDR_W'(col) + ADDR_W'(tap_dc(tap)) - ADDR_W'(1);
    rd_addr = ADDR_W'(RD_BASE) + rd_row * ADDR_W'(IMG_W) + rd_col;
    wr_addr = ADDR_W'(WR_BASE) + ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  end

endmodule

// File: rtl/pixel_window_sequencer.sv
// Walks interior pixels, reads each 3x3 window, hands it to the Sobel core and
// writes the result back. Define WINDOW_REUSE_EN to reuse two window columns.
module pixel_window_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_BASE = 0,
  parameter int WR_BASE = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  busy,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  write_done,
  output logic                  start_read,
  output logic [ADDR_W-1:0]     addr_r_mc,
  output logic                  start_write,
  output logic [ADDR_W-1:0]     addr_w_mc,
  output logic [DATA_W-1:0]     data_w,
  output logic                  win_valid,
  output logic [9*DATA_W-1:0]   win_data,
  input  logic                  result_valid,
  input  logic [DATA_W-1:0]     result_data,
  output logic                  done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_FIRST = RW'(1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 2);
  localparam logic [CW-1:0] COL_FIRST = CW'(1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 2);

`ifdef WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  if (IMG_W < 3 || IMG_H < 3) begin : g_bad_geom
    $error("pixel_window_sequencer: image must be at least 3x3");
  end
  if (longint'(RD_BASE) + longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W) ||
      longint'(WR_BASE) + longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W))
  begin : g_bad_map
    $error("pixel_window_sequencer: image regions do not fit in the address space");
  end

  state_t                          state, state_nx;
  logic [RW-1:0]                   row;
  logic [CW-1:0]                   col;
  logic [3:0]                      tap;
  logic                            partial;
  logic [NUM_TAPS-1:0][DATA_W-1:0] taps;
  logic [DATA_W-1:0]               result;
  logic [ADDR_W-1:0]               rd_addr;
  logic [ADDR_W-1:0]               wr_addr;

  window_addr_gen #(
    .IMG_W   (IMG_W),
    .ADDR_W  (ADDR_W),
    .RD_BASE (RD_BASE),
    .WR_BASE (WR_BASE),
    .ROW_W   (RW),
    .COL_W   (CW)
  ) u_addr (
    .row     (row),
    .col     (col),
    .tap     (tap),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr)
  );

  assign win_data = taps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Requests are held while their state is active; busy/write_done gate the exit.
  always_comb begin
    state_nx    = state;
    start_read  = 1'b0;
    addr_r_mc   = '0;
    start_write = 1'b0;
    addr_w_mc   = '0;
    data_w      = '0;
    win_valid   = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nx = ST_RD_REQ;
      ST_RD_REQ: begin
        start_read = 1'b1;
        addr_r_mc  = rd_addr;
        if (!busy && tap == TAP_LAST) state_nx = ST_WIN_OUT;
      end
      ST_WIN_OUT: begin
        win_valid = 1'b1;
        state_nx  = ST_RES_WAIT;
      end
      ST_RES_WAIT: if (result_valid) state_nx = ST_WR_REQ;
      ST_WR_REQ: begin
        start_write = 1'b1;
        addr_w_mc   = wr_addr;
        data_w      = result;
        if (write_done) state_nx = ST_NEXT;
      end
      ST_NEXT:     state_nx = (row == ROW_LAST && col == COL_LAST) ? ST_DONE : ST_RD_REQ;
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= ROW_FIRST;
      col     <= COL_FIRST;
      tap     <= TAP_FIRST;
      partial <= 1'b0;
      taps    <= '0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          row     <= ROW_FIRST;
          col     <= COL_FIRST;
          tap     <= TAP_FIRST;
          partial <= 1'b0;
        end
        ST_RD_REQ: if (!busy) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            if (tap == 4'(k)) taps[k] <= rd_data;
          end
          // A partial window only refills the right column: taps 2, 5, 8.
          if (tap != TAP_LAST) tap <= tap + (partial ? TAP_COL_STEP : TAP_STEP);
        end
        ST_RES_WAIT: if (result_valid) result <= result_data;
        ST_NEXT: begin
          if (col == COL_LAST) begin
            col     <= COL_FIRST;
            tap     <= TAP_FIRST;
            partial <= 1'b0;
            if (row != ROW_LAST) row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
            if (REUSE) begin
              taps[0] <= taps[1];
              taps[1] <= taps[2];
              taps[3] <= taps[4];
              taps[4] <= taps[5];
              taps[6] <= taps[7];
              taps[7] <= taps[8];
              tap     <= TAP_REUSE_FIRST;
              partial <= 1'b1;
            end else begin
              tap     <= TAP_FIRST;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
